note_sequencer: RTL and testbench

- Upstream stage of the square-wave generator: plays a melody stored in an external synchronous song ROM.
- Drives `note_period` (half period in CLOCK_50 cycles), `wave_select` and `note_enable` directly into the generator.
- Fetches one 16-bit entry per note and converts the note code to a half period through an internal pitch table.
- Times each note with a tempo counter and inserts a short silent articulation gap before the next note.

---
 rtl/note_sequencer.sv | 144 ++++++++++++++
 tb/tb_note_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song ROM player feeding the square-wave generator: one 16-bit entry per note, tempo-timed with a silent gap.
// Define NOTE_SEQ_LOOP_EN to add the loop input that restarts the song at address 0 after the last entry.
module note_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int TICK_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
`ifdef NOTE_SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [18:0]       note_period,
  output logic [1:0]        wave_select,
  output logic              note_enable,
  output logic              busy,
  output logic              done
);

  localparam int CYC_W = $clog2(64 * TICK_CYCLES + 1);
  localparam logic [CYC_W-1:0] TICK = CYC_W'(TICK_CYCLES);
  localparam logic [CYC_W-1:0] GAP  = CYC_W'(GAP_CYCLES);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] PLAY = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  logic [CYC_W-1:0] cyc_left;
  logic             last_flag;

  // Half period for codes 1..84: C2-octave base value shifted down by the octave index.
  function automatic logic [18:0] pitch_period(input logic [6:0] code);
    logic [6:0]  rem;
    logic [2:0]  oct;
    logic [18:0] base;
    rem = code - 7'd1;
    oct = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 7'd12) begin
        rem = rem - 7'd12;
        oct = oct + 3'd1;
      end
    end
    case (rem)
      7'd0:    base = 19'd382226;
      7'd1:    base = 19'd360773;
      7'd2:    base = 19'd340524;
      7'd3:    base = 19'd321412;
      7'd4:    base = 19'd303373;
      7'd5:    base = 19'd286346;
      7'd6:    base = 19'd270274;
      7'd7:    base = 19'd255105;
      7'd8:    base = 19'd240787;
      7'd9:    base = 19'd227273;
      7'd10:   base = 19'd214517;
      default: base = 19'd202478;
    endcase
    return base >> oct;
  endfunction

  logic [6:0]       code;
  logic             is_rest;
  logic [6:0]       dur_ticks;
  logic [CYC_W-1:0] cyc_load;

  always_comb begin
    code      = rom_data[6:0];
    is_rest   = (code == 7'd0) || (code > 7'd84);
    dur_ticks = (rom_data[12:7] == 6'd0) ? 7'd64 : {1'b0, rom_data[12:7]};
    cyc_load  = CYC_W'(dur_ticks) * TICK - CYC_W'(1);
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rom_addr    <= '0;
      note_period <= '0;
      wave_select <= '0;
      note_enable <= 1'b0;
      cyc_left    <= '0;
      last_flag   <= 1'b0;
    end else if (stop) begin
      state       <= IDLE;
      note_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr <= '0;
            state    <= WAIT;
          end
        end
        WAIT: state <= LOAD;
        LOAD: begin
          note_period <= is_rest ? 19'd0 : pitch_period(code);
          wave_select <= rom_data[14:13];
          note_enable <= !is_rest;
          cyc_left    <= cyc_load;
          last_flag   <= rom_data[15];
          state       <= PLAY;
        end
        PLAY: begin
          cyc_left <= cyc_left - CYC_W'(1);
          // The articulation gap is the final GAP_CYCLES cycles of the note.
          if (cyc_left == GAP) note_enable <= 1'b0;
          if (cyc_left == '0) begin
            note_enable <= 1'b0;
            if (last_flag || (rom_addr == '1)) begin
`ifdef NOTE_SEQ_LOOP_EN
              if (loop) begin
                rom_addr <= '0;
                state    <= WAIT;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= WAIT;
            end
          end
        end
        DONE: begin
          note_enable <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_CYCLES=8, GAP_CYCLES=2 and a synchronous song ROM model.
// The loop scenario runs only when NOTE_SEQ_LOOP_EN is defined.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
  logic        loop = 1'b0;
`endif
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [18:0] note_period;
  logic [1:0]  wave_select;
  logic        note_enable;
  logic        busy;
  logic        done;

  logic [15:0] rom [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  note_sequencer #(.ADDR_W(8), .TICK_CYCLES(8), .GAP_CYCLES(2)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
`ifdef NOTE_SEQ_LOOP_EN
    .loop        (loop),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note_period (note_period),
    .wave_select (wave_select),
    .note_enable (note_enable),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ent(input logic last, input logic [1:0] w,
                                      input logic [5:0] d, input logic [6:0] n);
    return {last, w, d, n};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Leaves the bench at the negedge right after the start edge (sequencer in WAIT).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples every negedge from the current one until busy drops or the bound expires.
  task automatic watch(input int bound, input logic [18:0] tp,
                       output int busy_n, output int en_n, output int done_n,
                       output int tp_n, output int p0_n,
                       output logic [18:0] p_first, output logic [1:0] w_first,
                       output logic [7:0] a_first, output logic last_done,
                       output logic tout);
    bit got_p = 0;
    int k = 0;
    busy_n = 0; en_n = 0; done_n = 0; tp_n = 0; p0_n = 0;
    p_first = '0; w_first = '0; a_first = rom_addr; last_done = 1'b0;
    while (busy && k < bound) begin
      busy_n++;
      if (note_enable) begin
        en_n++;
        if (!got_p) begin
          p_first = note_period;
          w_first = wave_select;
          got_p = 1;
        end
      end
      if (done) done_n++;
      if (note_period == tp) tp_n++;
      if (note_period == 19'd0) p0_n++;
      last_done = done;
      @(negedge clk);
      k++;
    end
    tout = busy;
  endtask

  int busy_n, en_n, done_n, tp_n, p0_n;
  logic [18:0] p_first;
  logic [1:0]  w_first;
  logic [7:0]  a_first;
  logic        last_done, tout;
  int cnt;

  initial begin
    clear_rom();
    repeat (3) @(negedge clk);
    check("reset_outputs", {rom_addr, note_period, wave_select, note_enable, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {rom_addr, note_period, wave_select, note_enable, busy, done}, 32'd0);

    // Single A2 note, 3 ticks, last.
    rom[0] = ent(1'b1, 2'b01, 6'd3, 7'd10);
    pulse_start();
    watch(200, 19'd227273, busy_n, en_n, done_n, tp_n, p0_n, p_first, w_first, a_first, last_done, tout);
    check("t1_timeout", tout, 0);
    check("t1_addr", a_first, 0);
    check("t1_period", p_first, 19'd227273);
    check("t1_wave", w_first, 2'b01);
    check("t1_enable_cycles", en_n, 22);
    check("t1_period_hold", tp_n, 25);
    check("t1_done_pulses", done_n, 1);
    check("t1_busy_falls_with_done", last_done, 1);
    check("t1_busy_cycles", busy_n, 27);

    // Note 22 (A3) for 1 tick, then a 2-tick rest marked last.
    clear_rom();
    rom[0] = ent(1'b0, 2'b00, 6'd1, 7'd22);
    rom[1] = ent(1'b1, 2'b10, 6'd2, 7'd0);
    pulse_start();
    watch(200, 19'd113636, busy_n, en_n, done_n, tp_n, p0_n, p_first, w_first, a_first, last_done, tout);
    check("t2_timeout", tout, 0);
    check("t2_period", p_first, 19'd113636);
    check("t2_period_cycles", tp_n, 10);
    check("t2_rest_cycles", p0_n, 17);
    check("t2_enable_cycles", en_n, 6);
    check("t2_done_pulses", done_n, 1);
    check("t2_busy_cycles", busy_n, 29);
    check("t2_rest_wave", wave_select, 2'b10);

    // Duration code 0 means 64 ticks.
    clear_rom();
    rom[0] = ent(1'b1, 2'b11, 6'd0, 7'd10);
    pulse_start();
    watch(2000, 19'd227273, busy_n, en_n, done_n, tp_n, p0_n, p_first, w_first, a_first, last_done, tout);
    check("t3_timeout", tout, 0);
    check("t3_enable_cycles", en_n, 510);
    check("t3_busy_cycles", busy_n, 515);

    // Stop in the middle of PLAY.
    clear_rom();
    rom[0] = ent(1'b1, 2'b01, 6'd3, 7'd10);
    pulse_start();
    repeat (5) @(negedge clk);
    check("t4_playing", note_enable, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_stop_outputs", {note_enable, busy, done}, 3'b000);
    check("t4_period_holds", note_period, 19'd227273);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    check("t4_no_done_after_stop", cnt, 0);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check("t4_stop_beats_start", cnt, 0);

    // Asynchronous reset during the second entry, then replay from address 0.
    clear_rom();
    rom[0] = ent(1'b0, 2'b00, 6'd1, 7'd22);
    rom[1] = ent(1'b1, 2'b10, 6'd2, 7'd0);
    pulse_start();
    repeat (13) @(negedge clk);
    check("t5_second_entry", rom_addr, 1);
    #2 reset = 1'b1;
    #1 check("t5_async_reset", {rom_addr, note_period, wave_select, note_enable, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start();
    watch(200, 19'd113636, busy_n, en_n, done_n, tp_n, p0_n, p_first, w_first, a_first, last_done, tout);
    check("t5_timeout", tout, 0);
    check("t5_restart_addr", a_first, 0);
    check("t5_period_cycles", tp_n, 10);
    check("t5_done_pulses", done_n, 1);

`ifdef NOTE_SEQ_LOOP_EN
    // Two-entry song looped twice, then loop dropped.
    begin
      logic [7:0] prev;
      int wraps = 0;
      int dn = 0;
      loop = 1'b1;
      pulse_start();
      prev = rom_addr;
      for (int i = 0; i < 60; i++) begin
        if (prev == 8'd1 && rom_addr == 8'd0) wraps++;
        if (done) dn++;
        prev = rom_addr;
        @(negedge clk);
      end
      check("t6_wraps", wraps, 2);
      check("t6_no_done_while_looping", dn, 0);
      loop = 1'b0;
      watch(200, 19'd113636, busy_n, en_n, done_n, tp_n, p0_n, p_first, w_first, a_first, last_done, tout);
      check("t6_timeout", tout, 0);
      check("t6_done_after_loop_drop", done_n, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
